// File: rtl/pipe_collision_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_collision_ctrl
//
// Game-logic stage that sits after the tick counter. Every change of the
// 4-bit tick count to a non-zero value is one scroll step for the pipe. The
// block respawns the pipe with a pseudo-random gap height, checks the box
// against the pipe and the floor, keeps the score, and reports the game state.
//
// Ports:
//   CLOCK_50        in   1  system clock
//   resetn          in   1  asynchronous active-low reset
//   current_number  in   4  tick count from the clock stage (0..10, wraps to 0)
//   key_press       in   1  start/restart key, active high, level
//   box_y           in   7  box top y (0 = top of screen)
//   pipe_x          out  8  pipe left x
//   gap_y           out  7  gap top y
//   collided        out  1  high while in CRASH; freezes the tick counter
//   score           out  8  pipes passed, saturating at 255
//   game_state      out  2  0 = IDLE, 1 = RUN, 2 = CRASH (FSM state, unmodified)
// ---------------------------------------------------------------------------
module pipe_collision_ctrl #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int PIPE_W   = 8,
    parameter int GAP_H    = 24,
    parameter int GAP_MIN  = 8,
    parameter int BOX_X    = 20,
    parameter int BOX_W    = 6,
    parameter int BOX_H    = 6,
    parameter int STEP     = 2
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] current_number,
    input  logic       key_press,
    input  logic [6:0] box_y,
    output logic [7:0] pipe_x,
    output logic [6:0] gap_y,
    output logic       collided,
    output logic [7:0] score,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2
    } state_e;

    localparam logic [7:0] PX_INIT   = 8'(SCREEN_W);
    localparam logic [6:0] GY_INIT   = 7'(GAP_MIN + 32);
    localparam logic [7:0] LFSR_INIT = 8'hA5;

    state_e     state_q, state_d;
    logic [7:0] pipe_x_q, pipe_x_d;
    logic [6:0] gap_y_q, gap_y_d;
    logic [7:0] score_q, score_d;
    logic       collided_q, collided_d;
    logic [3:0] prev_number_q, prev_number_d;
    logic [7:0] lfsr_q, lfsr_d;

    logic       step;
    logic       hit_x, hit_y, floor_hit, crash;
    logic [8:0] px9, gy9, by9;

    // Collision terms are widened to 9 bits so pipe_x + PIPE_W and
    // box_y + BOX_H cannot wrap.
    always_comb begin
        px9       = {1'b0, pipe_x_q};
        gy9       = {2'b00, gap_y_q};
        by9       = {2'b00, box_y};
        hit_x     = (px9 <= 9'(BOX_X + BOX_W - 1)) &&
                    ((px9 + 9'(PIPE_W - 1)) >= 9'(BOX_X));
        hit_y     = (by9 < gy9) || ((by9 + 9'(BOX_H)) > (gy9 + 9'(GAP_H)));
        floor_hit = (by9 + 9'(BOX_H)) > 9'(SCREEN_H);
        crash     = (hit_x && hit_y) || floor_hit;
    end

    always_comb begin
        state_d       = state_q;
        pipe_x_d      = pipe_x_q;
        gap_y_d       = gap_y_q;
        score_d       = score_q;
        prev_number_d = current_number;
        // Fibonacci taps 8,6,5,4; free-running so the gap height depends on
        // how long the player took.
        lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        // A change to 0 is a counter wrap or an upstream key reset, not a step.
        step = (current_number != prev_number_q) && (current_number != 4'd0);

        case (state_q)
            ST_IDLE: begin
                if (key_press) begin
                    state_d  = ST_RUN;
                    pipe_x_d = PX_INIT;
                    gap_y_d  = GY_INIT;
                    score_d  = 8'd0;
                end
            end
            ST_RUN: begin
                // Crash has priority: the frame that crashed is not scrolled.
                if (crash) begin
                    state_d = ST_CRASH;
                end else if (step) begin
                    if (pipe_x_q >= 8'(STEP)) begin
                        pipe_x_d = pipe_x_q - 8'(STEP);
                    end else begin
                        pipe_x_d = PX_INIT;
                        gap_y_d  = 7'(GAP_MIN) + {1'b0, lfsr_q[5:0]};
                        score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end
                end
            end
            ST_CRASH: begin
                if (key_press) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered from the next state so it rises together with CRASH.
        collided_d = (state_d == ST_CRASH);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            pipe_x_q      <= PX_INIT;
            gap_y_q       <= GY_INIT;
            score_q       <= 8'd0;
            collided_q    <= 1'b0;
            prev_number_q <= 4'd0;
            lfsr_q        <= LFSR_INIT;
        end else begin
            state_q       <= state_d;
            pipe_x_q      <= pipe_x_d;
            gap_y_q       <= gap_y_d;
            score_q       <= score_d;
            collided_q    <= collided_d;
            prev_number_q <= prev_number_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign pipe_x     = pipe_x_q;
    assign gap_y      = gap_y_q;
    assign score      = score_q;
    assign collided   = collided_q;
    assign game_state = state_q;

endmodule
